mem_bus_master: RTL and testbench

- Byte-stream bus initiator for the Hack memory map: RAM at 0x0000–0x1FFF, LED at 0x2000 (8192), button at 0x2001 (8193).
- Decodes serial command bytes (write/read bursts) from a host link into `address`/`in`/`load` cycles on `Memory`.
- Samples `Memory.out` and streams read data back as bytes.
- Sits between a UART byte receiver/transmitter pair and `Memory`; it is the host-side master driving the memory map.

---
 rtl/mem_bus_master.sv | 214 +++++++++++++++++++++
 tb/tb_mem_bus_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Host-side bus master: turns a byte stream of write/read burst commands into
// Memory address/in/load cycles and streams read data back as bytes.
module mem_bus_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] mem_address,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] BYTE_ACK = 8'h4B;
  localparam logic [7:0] BYTE_ERR = 8'h45;
  localparam logic [1:0] WAIT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  typedef enum logic [3:0] {
    IDLE,
    HDR_AH,
    HDR_AL,
    HDR_N,
    W_DH,
    W_DL,
    W_STROBE,
    W_ACK,
    R_ADDR,
    R_WAIT,
    R_TXH,
    R_TXL,
    ERR_TX
  } state_t;

  state_t      state;
  logic        is_write;
  logic [8:0]  count;
  logic [1:0]  wait_cnt;
  logic [7:0]  rdata_lo;
  logic        rx_take;
  logic        tx_take;

  assign rx_take = rx_valid && rx_ready;
  assign tx_take = tx_valid && tx_ready;

  // The read-data latch is split: tx_data itself carries the high byte while
  // rdata_lo keeps the low byte until the high byte has been consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      count       <= 9'd0;
      wait_cnt    <= 2'd0;
      rdata_lo    <= 8'h00;
      mem_address <= 16'h0000;
      mem_in      <= 16'h0000;
      mem_load    <= 1'b0;
      rx_ready    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_take) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              is_write <= (rx_data == OP_WRITE);
              state    <= HDR_AH;
            end else begin
              rx_ready <= 1'b0;
              tx_data  <= BYTE_ERR;
              tx_valid <= 1'b1;
              state    <= ERR_TX;
            end
          end
        end

        HDR_AH: begin
          if (rx_take) begin
            mem_address[15:8] <= rx_data;
            state             <= HDR_AL;
          end
        end

        HDR_AL: begin
          if (rx_take) begin
            mem_address[7:0] <= rx_data;
            state            <= HDR_N;
          end
        end

        // A length byte of zero encodes the maximum burst of 256 words.
        HDR_N: begin
          if (rx_take) begin
            count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            if (is_write) begin
              state <= W_DH;
            end else begin
              rx_ready <= 1'b0;
              state    <= R_ADDR;
            end
          end
        end

        W_DH: begin
          if (rx_take) begin
            mem_in[15:8] <= rx_data;
            state        <= W_DL;
          end
        end

        W_DL: begin
          if (rx_take) begin
            mem_in[7:0] <= rx_data;
            mem_load    <= 1'b1;
            rx_ready    <= 1'b0;
            state       <= W_STROBE;
          end
        end

        W_STROBE: begin
          mem_load    <= 1'b0;
          mem_address <= mem_address + 16'd1;
          count       <= count - 9'd1;
          if (count == 9'd1) begin
            tx_data  <= BYTE_ACK;
            tx_valid <= 1'b1;
            state    <= W_ACK;
          end else begin
            rx_ready <= 1'b1;
            state    <= W_DH;
          end
        end

        W_ACK: begin
          if (tx_take) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end

        // With zero latency the memory answers within the address cycle itself.
        R_ADDR: begin
          if (READ_LATENCY == 0) begin
            tx_data  <= mem_out[15:8];
            rdata_lo <= mem_out[7:0];
            tx_valid <= 1'b1;
            state    <= R_TXH;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= R_WAIT;
          end
        end

        R_WAIT: begin
          if (wait_cnt == 2'd0) begin
            tx_data  <= mem_out[15:8];
            rdata_lo <= mem_out[7:0];
            tx_valid <= 1'b1;
            state    <= R_TXH;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        R_TXH: begin
          if (tx_take) begin
            tx_data <= rdata_lo;
            state   <= R_TXL;
          end
        end

        // Address and count only advance once the whole word has left.
        R_TXL: begin
          if (tx_take) begin
            tx_valid    <= 1'b0;
            mem_address <= mem_address + 16'd1;
            count       <= count - 9'd1;
            if (count == 9'd1) begin
              rx_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= R_ADDR;
            end
          end
        end

        ERR_TX: begin
          if (tx_take) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          rx_ready <= 1'b0;
          tx_valid <= 1'b0;
          mem_load <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a Hack-style memory responder plus a word-level
// reference of the memory map that predicts every response byte and write.
module tb_mem_bus_master;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;

  mem_bus_master #(.READ_LATENCY(RL)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .mem_address(mem_address),
    .mem_in(mem_in),
    .mem_load(mem_load),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int readyMode = 0;
  logic btn = 1'b0;

  logic [15:0] simRam [0:8191];
  logic [15:0] simLed;
  bit          memReady;
  logic [15:0] refRam [0:8191];
  logic [15:0] refLed;

  logic [7:0]  gotTx[$];
  logic [7:0]  expTx[$];
  int          txStamp[$];
  logic [31:0] obsWrites[$];
  logic [31:0] expWrites[$];
  logic [15:0] wq[$];

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] simRead(input logic [15:0] a);
    if (a < 16'h2000) return simRam[a[12:0]];
    if (a == 16'h2000) return simLed;
    if (a == 16'h2001) return {15'b0, btn};
    return 16'h0000;
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    if (a < 16'h2000) return refRam[a[12:0]];
    if (a == 16'h2000) return refLed;
    if (a == 16'h2001) return {15'b0, btn};
    return 16'h0000;
  endfunction

  // Memory responder with one cycle of registered read latency.
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 8192; i++) simRam[i] <= pattern(16'(i));
      simLed   <= 16'h0000;
      memReady <= 1'b1;
    end else if (mem_load) begin
      if (mem_address < 16'h2000) simRam[mem_address[12:0]] <= mem_in;
      else if (mem_address == 16'h2000) simLed <= mem_in;
    end
    mem_out <= simRead(mem_address);
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial forever begin
    @(negedge clk);
    case (readyMode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (!reset && tx_valid && tx_ready) begin
      gotTx.push_back(tx_data);
      txStamp.push_back(cycle);
    end
    if (!reset && mem_load) obsWrites.push_back({mem_address, mem_in});
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got 0 required 1");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) checkOutput("rx_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic modelWrite(input logic [15:0] a, input logic [15:0] w);
    if (a < 16'h2000) refRam[a[12:0]] = w;
    else if (a == 16'h2000) refLed = w;
    expWrites.push_back({a, w});
  endtask

  task automatic startCmd();
    gotTx.delete();
    txStamp.delete();
    obsWrites.delete();
    expTx.delete();
    expWrites.delete();
  endtask

  task automatic finishCmd();
    int guard;
    guard = 0;
    while (gotTx.size() < expTx.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    checkOutput("tx_count", 32'(gotTx.size()), 32'(expTx.size()));
    foreach (expTx[i])
      if (i < gotTx.size()) checkOutput($sformatf("tx[%0d]", i), 32'(gotTx[i]), 32'(expTx[i]));
    checkOutput("wr_count", 32'(obsWrites.size()), 32'(expWrites.size()));
    foreach (expWrites[i])
      if (i < obsWrites.size()) checkOutput($sformatf("wr[%0d]", i), obsWrites[i], expWrites[i]);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] a, input logic [7:0] n);
    int cnt;
    logic [15:0] ad;
    logic [15:0] w;
    cnt = (n == 8'h00) ? 256 : int'(n);
    ad  = a;
    startCmd();
    sendByte(op);
    sendByte(a[15:8]);
    sendByte(a[7:0]);
    sendByte(n);
    for (int i = 0; i < cnt; i++) begin
      if (op == 8'h57) begin
        w = (wq.size() > 0) ? wq.pop_front() : 16'($urandom);
        sendByte(w[15:8]);
        sendByte(w[7:0]);
        modelWrite(ad, w);
      end else begin
        w = refRead(ad);
        expTx.push_back(w[15:8]);
        expTx.push_back(w[7:0]);
      end
      ad = ad + 16'd1;
    end
    if (op == 8'h57) expTx.push_back(8'h4B);
    finishCmd();
  endtask

  task automatic runBad(input logic [7:0] op);
    startCmd();
    sendByte(op);
    expTx.push_back(8'h45);
    finishCmd();
  endtask

  initial begin
    int kind;
    int sel;
    int guard;
    logic [15:0] a;
    logic [7:0] n;
    logic [7:0] op;

    for (int i = 0; i < 8192; i++) refRam[i] = pattern(16'(i));
    refLed = 16'h0000;
    repeat (3) @(negedge clk);

    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
    checkOutput("rst_mem_in", 32'(mem_in), 32'd0);
    checkOutput("rst_mem_load", 32'(mem_load), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rx_ready_low_at_release", 32'(rx_ready), 32'd0);
    @(negedge clk);
    checkOutput("rx_ready_first_cycle", 32'(rx_ready), 32'd1);

    // LED write
    wq = {16'h0001};
    applyStimulus(8'h57, 16'h2000, 8'd1);
    checkOutput("led_value", 32'(simLed), 32'd1);

    // Burst write then read back
    wq = {16'h08AE, 16'h3039};
    applyStimulus(8'h57, 16'h03E8, 8'd2);
    applyStimulus(8'h52, 16'h03E8, 8'd2);
    checkOutput("plan_word0", 32'({gotTx[0], gotTx[1]}), 32'h08AE);
    checkOutput("plan_word1", 32'({gotTx[2], gotTx[3]}), 32'h3039);

    // Address wrap on read and write, then a full 256-word burst
    applyStimulus(8'h52, 16'hFFFF, 8'd2);
    applyStimulus(8'h57, 16'hFFFF, 8'd2);
    applyStimulus(8'h52, 16'h0000, 8'd1);
    applyStimulus(8'h57, 16'h0F80, 8'd0);
    applyStimulus(8'h52, 16'h107E, 8'd3);

    // Minimum read throughput with tx_ready tied high
    applyStimulus(8'h52, 16'h0100, 8'd4);
    checkOutput("byte_gap", 32'(txStamp[1] - txStamp[0]), 32'd1);
    for (int k = 0; k < 3; k++)
      checkOutput("word_period", 32'(txStamp[2*k+2] - txStamp[2*k]), 32'(3 + RL));

    // Button read under host back-pressure
    btn = 1'b1;
    readyMode = 2;
    startCmd();
    sendByte(8'h52);
    sendByte(8'h20);
    sendByte(8'h01);
    sendByte(8'h01);
    guard = 0;
    while (!tx_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("bp_valid", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_data", 32'(tx_data), 32'h00);
      checkOutput("bp_addr", 32'(mem_address), 32'h2001);
      @(negedge clk);
    end
    readyMode = 0;
    expTx.push_back(8'h00);
    expTx.push_back(8'h01);
    finishCmd();

    // Unknown opcode, then a normal command
    runBad(8'h41);
    applyStimulus(8'h52, 16'h0000, 8'd1);

    // Reset after the high byte of word 2
    startCmd();
    sendByte(8'h57);
    sendByte(8'h00);
    sendByte(8'h40);
    sendByte(8'h03);
    sendByte(8'hBE);
    sendByte(8'hEF);
    checkOutput("strobe_load", 32'(mem_load), 32'd1);
    modelWrite(16'h0040, 16'hBEEF);
    sendByte(8'h12);
    reset = 1'b1;
    #1;
    checkOutput("abort_load", 32'(mem_load), 32'd0);
    checkOutput("abort_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    finishCmd();
    applyStimulus(8'h52, 16'h0040, 8'd2);

    // Reset while the strobe is high must drop mem_load without a clock
    startCmd();
    sendByte(8'h57);
    sendByte(8'h00);
    sendByte(8'h50);
    sendByte(8'h01);
    sendByte(8'hCA);
    sendByte(8'hFE);
    checkOutput("strobe2_load", 32'(mem_load), 32'd1);
    checkOutput("strobe2_addr", 32'(mem_address), 32'h0050);
    reset = 1'b1;
    #1;
    checkOutput("async_load_drop", 32'(mem_load), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    finishCmd();
    applyStimulus(8'h52, 16'h0050, 8'd1);

    // Randomized command mix
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 8);
      sel  = $urandom_range(0, 9);
      a = (sel == 0) ? 16'hFFFD : (sel == 1) ? 16'h1FFE : 16'($urandom_range(0, 16'h1FF0));
      n = 8'($urandom_range(1, 6));
      readyMode = $urandom_range(0, 1);
      if (kind < 4) begin
        applyStimulus(8'h57, a, n);
      end else if (kind < 8) begin
        applyStimulus(8'h52, a, n);
      end else begin
        op = 8'($urandom);
        if (op == 8'h52 || op == 8'h57) op = 8'h00;
        runBad(op);
      end
    end

    readyMode = 0;
    checkOutput("idle_rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("idle_tx_valid", 32'(tx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
